free_list: RTL and testbench

// Physical-register free list feeding the rename table: supplies new destination physical registers at rename
// and reclaims old destination registers at commit. Circular FIFO with head (allocate) and tail (free) pointers.

---
 rtl/free_list.sv | 158 +++++++++++++++
 tb/tb_free_list.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// Physical-register free list for the rename stage.
// Circular FIFO: head hands out registers, tail takes back committed ones.
module free_list #(
  parameter int NUM_SCALAR_INSTR  = 2,
  parameter int NUM_FREES         = 2,
  parameter int NUM_PHYS_REGS     = 64,
  parameter int NUM_ISA_REGISTERS = 32,
  parameter int NUM_CHECKPOINTS   = 4,
  localparam int PRW = $clog2(NUM_PHYS_REGS),
  localparam int CPW = $clog2(NUM_CHECKPOINTS)
) (
  input  logic                                  clk_i,
  input  logic                                  rstn_i,
  input  logic [NUM_SCALAR_INSTR-1:0]           read_head_i,
  input  logic [NUM_FREES-1:0]                  add_free_register_i,
  input  logic [NUM_FREES-1:0][PRW-1:0]         old_register_i,
  input  logic                                  do_checkpoint_i,
  input  logic                                  do_recover_i,
  input  logic                                  delete_checkpoint_i,
  input  logic [CPW-1:0]                        recover_checkpoint_i,
  input  logic                                  recover_commit_i,
  output logic [NUM_SCALAR_INSTR-1:0][PRW-1:0]  new_register_o,
  output logic [CPW-1:0]                        checkpoint_o,
  output logic                                  out_of_checkpoints_o,
  output logic                                  empty_o
);

  localparam int FREE_SIZE = NUM_PHYS_REGS - NUM_ISA_REGISTERS;
  localparam int IW = $clog2(FREE_SIZE);
  localparam int PW = IW + 1;
  localparam int NW = $clog2(NUM_CHECKPOINTS + 1);

  logic [PRW-1:0] fifo_q [FREE_SIZE];
  logic [PW-1:0]  snap_q [NUM_CHECKPOINTS];

  logic [PW-1:0]  head_q, tail_q;
  logic [PW-1:0]  head_d, tail_d;
  logic [PW-1:0]  count, count_d;
  logic [PW-1:0]  pop_cnt, free_cnt;
  logic [IW-1:0]  rd_idx;
  logic [IW-1:0]  wr_idx [NUM_FREES];
  logic [NUM_FREES-1:0] free_ok;

  logic [CPW-1:0] vhead_q, vtail_q;
  logic [NW-1:0]  num_q, num_d, rec_num;
  logic           pop_en, ckpt_en;

  assign count   = tail_q - head_q;
  assign count_d = tail_d - head_d;
  assign empty_o = count < PW'(NUM_SCALAR_INSTR);
  assign out_of_checkpoints_o =
    num_q == NW'(NUM_CHECKPOINTS - 1);

  assign pop_en  = ~empty_o & ~do_recover_i
                 & ~recover_commit_i;
  assign ckpt_en = do_checkpoint_i
                 & (num_q < NW'(NUM_CHECKPOINTS))
                 & ~do_recover_i & ~recover_commit_i;

  // Requesting slots read compacted entries from head onwards
  always_comb begin
    new_register_o = '0;
    pop_cnt = '0;
    rd_idx = '0;
    for (int i = 0; i < NUM_SCALAR_INSTR; i++) begin
      rd_idx = head_q[IW-1:0] + pop_cnt[IW-1:0];
      new_register_o[i] = fifo_q[rd_idx];
      pop_cnt = pop_cnt + PW'(read_head_i[i]);
    end
  end

  // p0 backs x0 and must never re-enter the list
  always_comb begin
    free_cnt = '0;
    free_ok = '0;
    for (int j = 0; j < NUM_FREES; j++) begin
      free_ok[j] = add_free_register_i[j]
                 & (|old_register_i[j]);
      wr_idx[j] = tail_q[IW-1:0] + free_cnt[IW-1:0];
      free_cnt = free_cnt + PW'(free_ok[j]);
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (recover_commit_i) begin
      head_d = {~tail_q[PW-1], tail_q[IW-1:0]};
    end else begin
      tail_d = tail_q + free_cnt;
      if (do_recover_i)
        head_d = snap_q[recover_checkpoint_i];
      else if (pop_en)
        head_d = head_q + pop_cnt;
    end
  end

  always_comb begin
    rec_num = '0;
    if (recover_checkpoint_i >= vtail_q)
      rec_num = NW'(recover_checkpoint_i - vtail_q);
    else
      rec_num = NW'(NUM_CHECKPOINTS) - NW'(vtail_q)
              + NW'(recover_checkpoint_i);
    num_d = num_q;
    if (recover_commit_i)
      num_d = '0;
    else if (do_recover_i)
      num_d = rec_num
            - NW'(delete_checkpoint_i && rec_num != '0);
    else
      num_d = num_q + NW'(ckpt_en)
            - NW'(delete_checkpoint_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < FREE_SIZE; k++)
        fifo_q[k] <= PRW'(NUM_ISA_REGISTERS + k);
      for (int c = 0; c < NUM_CHECKPOINTS; c++)
        snap_q[c] <= '0;
      head_q       <= '0;
      tail_q       <= {1'b1, {IW{1'b0}}};
      vhead_q      <= '0;
      vtail_q      <= '0;
      num_q        <= '0;
      checkpoint_o <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      num_q  <= num_d;
      if (recover_commit_i) begin
        vhead_q      <= '0;
        vtail_q      <= '0;
        checkpoint_o <= '0;
      end else begin
        for (int j = 0; j < NUM_FREES; j++)
          if (free_ok[j])
            fifo_q[wr_idx[j]] <= old_register_i[j];
        checkpoint_o <= vhead_q;
        if (do_recover_i) begin
          vhead_q <= recover_checkpoint_i;
        end else if (ckpt_en) begin
          snap_q[vhead_q] <= head_d;
          vhead_q <= vhead_q + CPW'(1);
        end
        if (delete_checkpoint_i)
          vtail_q <= vtail_q + CPW'(1);
      end
    end
  end

  // Freeing into a full list would overwrite live entries
  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (!rstn_i)
    count_d <= PW'(FREE_SIZE));

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: allocation, wrap, checkpoints,
// recovery and exception flush, checked through a scoreboard queue.
module tb_free_list;

  logic            clk;
  logic            rst_n;
  logic [1:0]      read_head;
  logic [1:0]      add_free;
  logic [1:0][5:0] old_reg;
  logic            do_ckpt;
  logic            do_rec;
  logic            del_ckpt;
  logic [1:0]      rec_ckpt;
  logic            rec_commit;
  logic [1:0][5:0] new_reg;
  logic [1:0]      ckpt;
  logic            ooc;
  logic            empty;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  free_list dut (
    .clk_i               (clk),
    .rstn_i              (rst_n),
    .read_head_i         (read_head),
    .add_free_register_i (add_free),
    .old_register_i      (old_reg),
    .do_checkpoint_i     (do_ckpt),
    .do_recover_i        (do_rec),
    .delete_checkpoint_i (del_ckpt),
    .recover_checkpoint_i(rec_ckpt),
    .recover_commit_i    (rec_commit),
    .new_register_o      (new_reg),
    .checkpoint_o        (ckpt),
    .out_of_checkpoints_o(ooc),
    .empty_o             (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    read_head  = '0;
    add_free   = '0;
    old_reg    = '0;
    do_ckpt    = 1'b0;
    do_rec     = 1'b0;
    del_ckpt   = 1'b0;
    rec_ckpt   = '0;
    rec_commit = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_v(string tag, int v);
    sb.push_back('{tag, v});
  endtask

  task automatic chk(logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_underflow got %0d exp none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s got %0d exp %0d", e.tag, obs, e.v);
      end
    end
  endtask

  // Buffer contents before the flush: slots 0..4 refilled, rest original
  function automatic int slot_val(int i);
    int x;
    x = i % 32;
    return (x < 5) ? 40 + x : 32 + x;
  endfunction

  initial begin
    idle();
    rst_n = 1'b0;
    read_head = 2'b11;
    exp_v("rst_nr0", 32); exp_v("rst_nr1", 33);
    exp_v("rst_empty", 0); exp_v("rst_ooc", 0);
    exp_v("rst_ckpt", 0);
    #12;
    chk(new_reg[0]); chk(new_reg[1]);
    chk(empty); chk(ooc); chk(ckpt);
    read_head = '0;
    #6 rst_n = 1'b1;
    tick();

    // first allocations
    read_head = 2'b11;
    exp_v("a0_nr0", 32); exp_v("a0_nr1", 33);
    #1 chk(new_reg[0]); chk(new_reg[1]);
    tick();
    exp_v("a1_nr0", 34); exp_v("a1_nr1", 35);
    exp_v("a1_empty", 0);
    #1 chk(new_reg[0]); chk(new_reg[1]); chk(empty);
    tick();

    // checkpoint at head 4 together with 2 pops
    do_ckpt = 1'b1;
    exp_v("c0_nr0", 36); exp_v("c0_nr1", 37);
    #1 chk(new_reg[0]); chk(new_reg[1]);
    tick();
    do_ckpt = 1'b0;
    exp_v("c0_label", 0);
    chk(ckpt);
    for (int k = 0; k < 3; k++) begin
      exp_v("c_nr0", 38 + 2 * k); exp_v("c_nr1", 39 + 2 * k);
      #1 chk(new_reg[0]); chk(new_reg[1]);
      tick();
    end
    exp_v("c_label_next", 1);
    chk(ckpt);

    // recover to label 0: allocation this cycle is ignored
    do_rec = 1'b1;
    rec_ckpt = 2'd0;
    tick();
    do_rec = 1'b0;
    exp_v("rec_nr0", 38); exp_v("rec_nr1", 39);
    #1 chk(new_reg[0]); chk(new_reg[1]);
    read_head = 2'b10;
    exp_v("rec_single", 38);
    #1 chk(new_reg[1]);
    tick();

    // drain to empty, head ends at index 31
    read_head = 2'b11;
    for (int k = 0; k < 12; k++) begin
      exp_v("d_nr0", 39 + 2 * k); exp_v("d_nr1", 40 + 2 * k);
      exp_v("d_empty", 0);
      #1 chk(new_reg[0]); chk(new_reg[1]); chk(empty);
      tick();
    end
    exp_v("d_empty_end", 1);
    chk(empty);

    // requests while empty are ignored; frees refill
    add_free = 2'b11;
    old_reg[0] = 6'd40;
    old_reg[1] = 6'd41;
    tick();
    exp_v("f_empty", 0);
    chk(empty);

    // pops straddle index 31 -> 0 while two frees land
    old_reg[0] = 6'd42;
    old_reg[1] = 6'd43;
    exp_v("w_nr0", 63); exp_v("w_nr1", 40);
    #1 chk(new_reg[0]); chk(new_reg[1]);
    tick();

    // slot 0 frees p0, which must be dropped
    old_reg[0] = 6'd0;
    old_reg[1] = 6'd44;
    exp_v("z_nr0", 41); exp_v("z_nr1", 42);
    #1 chk(new_reg[0]); chk(new_reg[1]);
    tick();
    add_free = '0;
    old_reg = '0;
    exp_v("z2_nr0", 43); exp_v("z2_nr1", 44);
    exp_v("z2_empty", 0);
    #1 chk(new_reg[0]); chk(new_reg[1]); chk(empty);
    tick();
    exp_v("z2_empty_end", 1);
    chk(empty);

    // fill the checkpoint ring; the fifth request is dropped
    idle();
    do_ckpt = 1'b1;
    for (int c = 0; c < 5; c++) begin
      exp_v("k_label", (c < 4) ? c : 0);
      exp_v("k_ooc", (c == 2) ? 1 : 0);
      tick();
      chk(ckpt); chk(ooc);
    end
    do_ckpt = 1'b0;
    tick();
    exp_v("k_drop", 0);
    chk(ckpt);
    del_ckpt = 1'b1;
    tick();
    del_ckpt = 1'b0;
    exp_v("k_del_ooc", 1);
    chk(ooc);
    do_ckpt = 1'b1;
    tick();
    do_ckpt = 1'b0;
    exp_v("k_refill_ooc", 0);
    chk(ooc);

    // exception flush with simultaneous free/checkpoint/delete
    rec_commit = 1'b1;
    do_ckpt = 1'b1;
    del_ckpt = 1'b1;
    read_head = 2'b11;
    add_free = 2'b11;
    old_reg[0] = 6'd50;
    old_reg[1] = 6'd51;
    tick();
    idle();
    exp_v("x_ckpt", 0); exp_v("x_empty", 0); exp_v("x_ooc", 0);
    chk(ckpt); chk(empty); chk(ooc);
    tick();
    exp_v("x_vhead", 0);
    chk(ckpt);

    // all 32 entries are available again
    read_head = 2'b11;
    for (int k = 0; k < 16; k++) begin
      exp_v("r_nr0", slot_val(5 + 2 * k));
      exp_v("r_nr1", slot_val(6 + 2 * k));
      exp_v("r_empty", 0);
      #1 chk(new_reg[0]); chk(new_reg[1]); chk(empty);
      tick();
    end
    idle();
    exp_v("r_empty_end", 1);
    chk(empty);

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL sb_leftover got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
